// File: rtl/bai2_pkg.sv
// Shared definitions for the binary-to-BCD conversion stage.
// Holds the converter state encoding, the fixed field widths and the marker
// value that replaces a result when the incoming word does not fit in 16 bits.
package bai2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;
    localparam int CNT_W  = 5;

    // Not a legal BCD pattern, so downstream logic can recognise it as "no number".
    localparam logic [4*DIGITS-1:0] INVALID_BCD = 20'hFFFFF;

endpackage

// File: rtl/bcd_digit_adj.sv
// One digit of the double-dabble correction step.
// A BCD digit of 5 or more would carry past 9 when doubled by the following
// shift, so it is pre-biased by 3 to make the carry land in the next digit.
//
// Ports:
//   digit    - current 4-bit BCD digit
//   adjusted - digit, plus 3 when digit >= 5
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin16_to_bcd_seq.sv
// Sequential 16-bit binary to 5-digit packed BCD converter.
// Captures the scaler's 32-bit word on a rising edge of its done flag, rejects
// values that need more than 16 bits, and otherwise converts with one
// double-dabble iteration per clock. The result register holds its value
// between conversions.
//
// Ports:
//   clk_i   - clock, all state changes on the rising edge
//   rst_i   - synchronous, active-low reset
//   data_i  - scaled word from the scaler
//   valid_i - scaler done level; a rising edge requests a conversion
//   bcd_o   - packed BCD result, digit 4 in the top nibble
//   done_o  - one-cycle pulse, bcd_o/err_o valid from this cycle on
//   busy_o  - high while a conversion is in progress
//   err_o   - upper bits of data_i were nonzero at the last start
module bin16_to_bcd_seq #(
    parameter int IN_W   = 32,
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IN_W-1:0]       data_i,
    input  logic                  valid_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  err_o
);

    import bai2_pkg::*;

    state_t                state;
    state_t                next_state;
    logic                  valid_q;
    logic [BIN_W-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   bcd_sr;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_shifted;
    logic [CNT_W-1:0]      cnt;
    logic                  start;
    logic                  in_range;
    logic                  load;
    logic                  reject;
    logic                  shift_en;
    logic                  last_iter;

    // Per-digit +3 correction applied to the whole BCD register each iteration.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (bcd_sr[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // After correction, the BCD register shifts left and takes the binary MSB.
    assign bcd_shifted = (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_sr[BIN_W-1]};

    assign in_range  = (data_i[IN_W-1:BIN_W] == '0);
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    // DONE accepts a start as well as IDLE: the result is already registered
    // when the pulse is shown, so a new request seen on that edge loses nothing
    // and back-to-back conversions run at one every 17 clocks.
    assign start = valid_i & ~valid_q & ((state == IDLE) || (state == DONE));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and datapath controls.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        reject     = 1'b0;
        shift_en   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    next_state = IDLE;
                end
                if (start) begin
                    if (in_range) begin
                        load       = 1'b1;
                        next_state = SHIFT;
                    end else begin
                        reject     = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Edge detector, shift registers, iteration counter and result registers.
    // bcd_o is written only when entering DONE, so it never shows partial sums.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            bcd_o   <= '0;
            err_o   <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (load) begin
                bin_sr <= data_i[BIN_W-1:0];
                bcd_sr <= '0;
                cnt    <= '0;
                err_o  <= 1'b0;
            end else if (reject) begin
                err_o  <= 1'b1;
                bcd_o  <= INVALID_BCD;
            end else if (shift_en) begin
                bcd_sr <= bcd_shifted;
                bin_sr <= bin_sr << 1;
                cnt    <= cnt + 1'b1;
                if (last_iter) begin
                    bcd_o <= bcd_shifted;
                end
            end
        end
    end

    assign done_o = (state == DONE);
    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Self-checking bench for bin16_to_bcd_seq.
// A cycle-level behavioural model predicts every output from decimal
// arithmetic; a compare process checks it each cycle, and directed cases pin
// both the DUT and the model to hand-computed BCD values and latencies.
module tb_bin16_to_bcd_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic [19:0] bcd_o;
    logic        done_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    bit check_en = 1'b0;

    logic [19:0] m_bcd = '0;
    logic        m_err = 1'b0;
    logic        m_done = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_prev_valid = 1'b0;
    logic        m_rise;
    int          m_remaining = 0;
    int          m_pending = 0;

    bin16_to_bcd_seq #(
        .IN_W   (32),
        .BIN_W  (16),
        .DIGITS (5)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .bcd_o   (bcd_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Decimal digits of a number, packed four bits per digit.
    function automatic logic [19:0] to_bcd(input int value);
        logic [19:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Timeline model: a request is accepted when no conversion is pending,
    // in-range values finish 16 clocks later, out-of-range ones finish at once.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            m_bcd = '0;
            m_err = 1'b0;
            m_done = 1'b0;
            m_busy = 1'b0;
            m_prev_valid = 1'b0;
            m_remaining = 0;
        end else begin
            m_rise = valid_i && !m_prev_valid;
            m_prev_valid = valid_i;
            m_done = 1'b0;
            if (m_remaining > 0) begin
                m_remaining--;
                if (m_remaining == 0) begin
                    m_done = 1'b1;
                    m_bcd = to_bcd(m_pending);
                end
            end else if (m_rise) begin
                if (data_i[31:16] != 16'h0) begin
                    m_err = 1'b1;
                    m_bcd = 20'hFFFFF;
                    m_done = 1'b1;
                end else begin
                    m_err = 1'b0;
                    m_pending = int'(data_i[15:0]);
                    m_remaining = 16;
                end
            end
            m_busy = (m_remaining > 0) || m_done;
        end
    end

    // Done pulses seen, sampled just after each active edge.
    always @(posedge clk_i) begin
        #1;
        if (done_o === 1'b1) begin
            done_count++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_i) begin
        if (check_en) begin
            check_output("model_bcd_o", bcd_o, m_bcd);
            check_output("model_done_o", done_o, m_done);
            check_output("model_busy_o", busy_o, m_busy);
            check_output("model_err_o", err_o, m_err);
        end
    end

    // Waits for done_o on falling edges, bounded; returns the edges waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (done_o !== 1'b1 && n < 60);
        check_output("done_seen", done_o, 1'b1);
    endtask

    // Raises valid_i with a word and checks the result and its latency.
    task automatic apply_stimulus(input logic [31:0] d, input logic [19:0] exp_bcd,
                                  input logic exp_err, input int exp_wait,
                                  input bit release_valid);
        int n;
        data_i = d;
        valid_i = 1'b1;
        wait_done(n);
        check_output("latency", n, exp_wait);
        check_output("bcd_o", bcd_o, exp_bcd);
        check_output("model_pin", m_bcd, exp_bcd);
        check_output("err_o", err_o, exp_err);
        if (release_valid) begin
            valid_i = 1'b0;
            repeat (3) @(negedge clk_i);
        end
    endtask

    initial begin
        int n;
        int c0;

        @(posedge clk_i);
        check_en = 1'b1;
        repeat (2) @(negedge clk_i);
        check_output("reset_bcd_o", bcd_o, 20'h0);
        check_output("reset_done_o", done_o, 1'b0);
        check_output("reset_busy_o", busy_o, 1'b0);
        check_output("reset_err_o", err_o, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);

        apply_stimulus(32'h0000FFFF, 20'h65535, 1'b0, 17, 1'b1);
        apply_stimulus(32'h000004D2, 20'h01234, 1'b0, 17, 1'b1);
        apply_stimulus(32'h00000000, 20'h00000, 1'b0, 17, 1'b1);
        apply_stimulus(32'h00010000, 20'hFFFFF, 1'b1, 1, 1'b1);
        apply_stimulus(32'h00000007, 20'h00007, 1'b0, 17, 1'b1);

        // Level held high for 40 clocks gives a single conversion.
        c0 = done_count;
        apply_stimulus(32'h00000009, 20'h00009, 1'b0, 17, 1'b0);
        repeat (23) @(negedge clk_i);
        check_output("hold_one_done", done_count - c0, 1);
        valid_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // A second rising edge during SHIFT is ignored.
        c0 = done_count;
        data_i = 32'd100;
        valid_i = 1'b1;
        repeat (5) @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i = 32'd5;
        @(negedge clk_i);
        valid_i = 1'b0;
        wait_done(n);
        check_output("pulse_latency", n, 10);
        check_output("pulse_bcd_o", bcd_o, 20'h00100);
        repeat (20) @(negedge clk_i);
        check_output("pulse_one_done", done_count - c0, 1);

        // Reset in the middle of SHIFT discards the partial result.
        data_i = 32'h0000FFFF;
        valid_i = 1'b1;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        data_i = 32'd42;
        @(negedge clk_i);
        check_output("midrst_bcd_o", bcd_o, 20'h0);
        check_output("midrst_done_o", done_o, 1'b0);
        check_output("midrst_busy_o", busy_o, 1'b0);
        check_output("midrst_err_o", err_o, 1'b0);
        rst_i = 1'b1;
        wait_done(n);
        check_output("after_rst_latency", n, 17);
        check_output("after_rst_bcd_o", bcd_o, 20'h00042);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Back-to-back: new request seen on the edge after the done pulse.
        c0 = done_count;
        data_i = 32'd31415;
        valid_i = 1'b1;
        repeat (16) @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        check_output("b2b_first_done", done_o, 1'b1);
        check_output("b2b_first_bcd_o", bcd_o, 20'h31415);
        data_i = 32'd65000;
        valid_i = 1'b1;
        wait_done(n);
        check_output("b2b_spacing", n, 17);
        check_output("b2b_second_bcd_o", bcd_o, 20'h65000);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_output("b2b_two_dones", done_count - c0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
